// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM.
//   state_t      : FSM state encodings (3 encodings unused, recovered to IF)
//   alu_cls_t    : how a state chooses its ALU operation
//   ALU_*        : datapath ALU operation codes
//   OP_* / FN_*  : supported opcode and R-type funct values
//   SRCA_*/SRCB_*/PCSRC_*/DST_*/M2R_* : datapath mux selects
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IF  = 4'd0,  S_ID  = 4'd1,  S_EXR = 4'd2,  S_EXI = 4'd3,
        S_WBR = 4'd4,  S_WBI = 4'd5,  S_MA  = 4'd6,  S_MRD = 4'd7,
        S_WBL = 4'd8,  S_MWR = 4'd9,  S_BR  = 4'd10, S_JMP = 4'd11,
        S_JAL = 4'd12
    } state_t;

    // AC_DECODE is used in ID: ALU does PC+offset, decoder validates opcode.
    typedef enum logic [2:0] {
        AC_ADD, AC_SUB, AC_FUNCT, AC_IMM, AC_DECODE
    } alu_cls_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_LUI = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic       SRCA_PC     = 1'b0;
    localparam logic       SRCA_REG    = 1'b1;
    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;
    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MDR = 2'd1;
    localparam logic [1:0] M2R_PC  = 2'd2;

    // States that hold a memory access open until mem_ready.
    function automatic logic is_wait_state(state_t s);
        return (s == S_IF) || (s == S_MRD) || (s == S_MWR);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU operation decoder.
//   cls     in  : ALU class of the current state
//   opcode  in  : IR[31:26]
//   funct   in  : IR[5:0]
//   alu_op  out : ALU operation code
//   illegal out : unsupported opcode (AC_DECODE) or funct (AC_FUNCT)
module alu_op_decode
    import mc_ctrl_pkg::*;
(
    input  alu_cls_t   cls,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       illegal
);

    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (cls)
            AC_SUB: alu_op = ALU_SUB;
            AC_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: illegal = 1'b1;
                endcase
            end
            AC_IMM: begin
                // Only reached for I-type arithmetic; addi falls to the ADD default.
                case (opcode)
                    OP_SLTI: alu_op = ALU_SLT;
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    OP_XORI: alu_op = ALU_XOR;
                    OP_LUI:  alu_op = ALU_LUI;
                    default: alu_op = ALU_ADD;
                endcase
            end
            AC_DECODE: begin
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
                    OP_XORI, OP_LUI, OP_BEQ, OP_BNE, OP_J, OP_JAL: illegal = 1'b0;
                    default: illegal = 1'b1;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) with memory ready stalls.
//   clk, rst_n          : clock, synchronous active-low reset
//   opcode, funct       : instruction fields from IR
//   zero                : ALU zero flag, used in BR
//   mem_ready           : memory completes the pending access this cycle
//   alu_op, alu_src_a/b : ALU control
//   pc_src, pc_write    : PC update control
//   iord, mem_read/write: memory port control
//   ir_write, reg_dst, mem_to_reg, reg_write : IR / register file control
//   state               : current state (debug)
//   err_illegal, err_timeout : sticky error flags
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int ST_W   = 4,
    parameter int MEM_TO = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic            zero,
    input  logic            mem_ready,
    output logic [2:0]      alu_op,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      pc_src,
    output logic            pc_write,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic [1:0]      reg_dst,
    output logic [1:0]      mem_to_reg,
    output logic            reg_write,
    output logic [ST_W-1:0] state,
    output logic            err_illegal,
    output logic            err_timeout
);

    localparam int CNT_W = (MEM_TO > 1) ? $clog2(MEM_TO + 1) : 1;

    state_t             state_q, state_d;
    alu_cls_t           cls;
    logic               dec_illegal;
    logic [CNT_W-1:0]   wait_cnt;
    logic               timeout;

    assign state = ST_W'(state_q);

    // mem_ready wins over a timeout landing in the same cycle.
    assign timeout = (MEM_TO != 0) && is_wait_state(state_q) && !mem_ready &&
                     (wait_cnt == CNT_W'(MEM_TO));

    alu_op_decode u_dec (
        .cls     (cls),
        .opcode  (opcode),
        .funct   (funct),
        .alu_op  (alu_op),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IF;
            wait_cnt    <= '0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            // Counts only while an access is stalled; any exit clears it, so
            // every entry into IF/MRD/MWR starts from zero.
            if (is_wait_state(state_q) && !mem_ready && !timeout)
                wait_cnt <= (&wait_cnt) ? wait_cnt : wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (dec_illegal) err_illegal <= 1'b1;
            if (timeout)     err_timeout <= 1'b1;
        end
    end

    always_comb begin
        state_d    = S_IF;
        cls        = AC_ADD;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REG;
        pc_src     = PCSRC_ALU;
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = DST_RT;
        mem_to_reg = M2R_ALU;
        reg_write  = 1'b0;
        // While reset is held every output stays quiescent so memory sees
        // any pending access dropped.
        if (rst_n) begin
            case (state_q)
                S_IF: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_ID;
                    end
                end
                S_ID: begin
                    alu_src_b = SRCB_IMM_SH;
                    cls       = AC_DECODE;
                    case (opcode)
                        OP_RTYPE:     state_d = S_EXR;
                        OP_LW, OP_SW: state_d = S_MA;
                        OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                                      state_d = S_EXI;
                        OP_BEQ, OP_BNE: state_d = S_BR;
                        OP_J:         state_d = S_JMP;
                        OP_JAL:       state_d = S_JAL;
                        default:      state_d = S_IF;
                    endcase
                end
                S_EXR: begin
                    alu_src_a = SRCA_REG;
                    cls       = AC_FUNCT;
                    state_d   = dec_illegal ? S_IF : S_WBR;
                end
                S_EXI: begin
                    alu_src_a = SRCA_REG;
                    alu_src_b = SRCB_IMM;
                    cls       = AC_IMM;
                    state_d   = S_WBI;
                end
                S_WBR: begin
                    reg_write = 1'b1;
                    reg_dst   = DST_RD;
                end
                S_WBI: reg_write = 1'b1;
                S_MA: begin
                    alu_src_a = SRCA_REG;
                    alu_src_b = SRCB_IMM;
                    state_d   = (opcode == OP_SW) ? S_MWR : S_MRD;
                end
                S_MRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                    if (mem_ready)    state_d = S_WBL;
                    else if (timeout) state_d = S_IF;
                    else              state_d = S_MRD;
                end
                S_WBL: begin
                    reg_write  = 1'b1;
                    mem_to_reg = M2R_MDR;
                end
                S_MWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                    state_d   = (mem_ready || timeout) ? S_IF : S_MWR;
                end
                S_BR: begin
                    alu_src_a = SRCA_REG;
                    cls       = AC_SUB;
                    pc_src    = PCSRC_ALUOUT;
                    pc_write  = (opcode == OP_BNE) ? !zero : zero;
                end
                S_JMP: begin
                    pc_src   = PCSRC_JUMP;
                    pc_write = 1'b1;
                end
                S_JAL: begin
                    pc_src     = PCSRC_JUMP;
                    pc_write   = 1'b1;
                    reg_write  = 1'b1;
                    reg_dst    = DST_RA;
                    mem_to_reg = M2R_PC;
                end
                default: state_d = S_IF;
            endcase
        end
    end

endmodule
